// File: rtl/softmax_pkg.sv
// Shared types and floating-point helpers for the softmax max-search stage.
// Optional feature macro used by this slice: SOFTMAX_NAN_CHECK_EN.
package softmax_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_REDUCE,
    ST_DONE
  } state_t;

  // Wide enough for any float format this stage is expected to handle.
  localparam int unsigned FP_MAX_W = 64;
  typedef logic [FP_MAX_W-1:0] fp_word_t;

  // -inf: sign set, exponent all ones, mantissa zero.
  function automatic fp_word_t fp_neg_inf(input int unsigned exp_w, input int unsigned mant_w);
    fp_word_t ones;
    ones = (fp_word_t'(1) << (exp_w + 1)) - fp_word_t'(1);
    return ones << mant_w;
  endfunction

  // Canonical quiet NaN: sign clear, exponent all ones, only the mantissa MSB set.
  function automatic fp_word_t fp_qnan(input int unsigned exp_w, input int unsigned mant_w);
    fp_word_t exp_ones;
    exp_ones = (fp_word_t'(1) << exp_w) - fp_word_t'(1);
    return (exp_ones << mant_w) | (fp_word_t'(1) << (mant_w - 1));
  endfunction

  // Maps a sign-magnitude float onto an unsigned key whose integer order
  // matches the float order: negatives are inverted, positives get the MSB set.
  function automatic fp_word_t fp_key(input fp_word_t x, input int unsigned width);
    fp_word_t mask;
    fp_word_t msb;
    mask = (fp_word_t'(1) << width) - fp_word_t'(1);
    msb  = fp_word_t'(1) << (width - 1);
    if ((x & msb) != '0) begin
      return ~x & mask;
    end
    return (x | msb) & mask;
  endfunction

endpackage

// File: rtl/softmax_max_reduce_if.sv
// Request / memory-read / result bundle of the softmax max-search stage.
// nan_flag exists only when SOFTMAX_NAN_CHECK_EN is defined.
interface softmax_max_reduce_if #(
  parameter int DATAWIDTH = 16,
  parameter int NUM       = 4,
  parameter int ADDRSIZE  = 8
);
  localparam int LW = $clog2(NUM + 1);

  logic                     start;
  logic [ADDRSIZE-1:0]      addr_limit;
  logic [LW-1:0]            last_valid;
  logic [DATAWIDTH*NUM-1:0] inp;
  logic                     rd_en;
  logic [ADDRSIZE-1:0]      addr;
  logic                     busy;
  logic [DATAWIDTH-1:0]     max_out;
  logic                     max_valid;
`ifdef SOFTMAX_NAN_CHECK_EN
  logic                     nan_flag;

  modport master (output start, addr_limit, last_valid, inp,
                  input  rd_en, addr, busy, max_out, max_valid, nan_flag);
  modport slave  (input  start, addr_limit, last_valid, inp,
                  output rd_en, addr, busy, max_out, max_valid, nan_flag);
`else
  modport master (output start, addr_limit, last_valid, inp,
                  input  rd_en, addr, busy, max_out, max_valid);
  modport slave  (input  start, addr_limit, last_valid, inp,
                  output rd_en, addr, busy, max_out, max_valid);
`endif
endinterface

// File: rtl/softmax_max_reduce_fp_max2.sv
// Combinational two-input float max. Returns a unless b is strictly larger;
// +0 and -0 are treated as equal so the first operand's pattern survives.
module fp_max2
  import softmax_pkg::*;
#(
  parameter int DATAWIDTH = 16
) (
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] y
);

  fp_word_t key_a;
  fp_word_t key_b;
  logic     both_zero;
  logic     b_wins;

  // Order both operands by key and pick the winner, a on ties.
  always_comb begin
    key_a     = fp_key(fp_word_t'(a), DATAWIDTH);
    key_b     = fp_key(fp_word_t'(b), DATAWIDTH);
    both_zero = (a[DATAWIDTH-2:0] == '0) && (b[DATAWIDTH-2:0] == '0);
    b_wins    = (key_b > key_a) && !both_zero;
    y         = b_wins ? b : a;
  end

endmodule

// File: rtl/softmax_max_reduce.sv
// Streams NUM-lane float words from addresses 0..addr_limit, keeps a running
// per-lane max and reduces the lanes to one global maximum.
// Optional NaN detection is compiled in with SOFTMAX_NAN_CHECK_EN.
module softmax_max_reduce
  import softmax_pkg::*;
#(
  parameter int DATAWIDTH = 16,
  parameter int EXPWIDTH  = 5,
  parameter int MANTWIDTH = 10,
  parameter int NUM       = 4,
  parameter int ADDRSIZE  = 8,
  parameter int RD_LAT    = 1
) (
  input logic                 clk,
  input logic                 reset,
  softmax_max_reduce_if.slave bus
);

  localparam int LW   = $clog2(NUM + 1);
  localparam int LOGN = $clog2(NUM);
  localparam int PADN = 1 << LOGN;

  localparam fp_word_t             NEG_INF_W = fp_neg_inf(EXPWIDTH, MANTWIDTH);
  localparam logic [DATAWIDTH-1:0] NEG_INF   = NEG_INF_W[DATAWIDTH-1:0];
`ifdef SOFTMAX_NAN_CHECK_EN
  localparam fp_word_t             QNAN_W    = fp_qnan(EXPWIDTH, MANTWIDTH);
  localparam logic [DATAWIDTH-1:0] QNAN      = QNAN_W[DATAWIDTH-1:0];
`endif

  state_t               state, state_nx;
  logic                 start_acc;
  logic                 issue;
  logic                 issue_last;
  logic                 busy_c;
  logic                 max_valid_c;
  logic [ADDRSIZE-1:0]  limit_q;
  logic [ADDRSIZE-1:0]  addr_q;
  logic [LW-1:0]        last_valid_q;
  logic [RD_LAT-1:0]    tag_v;
  logic [RD_LAT-1:0]    tag_l;
  logic                 tag_out_v;
  logic                 tag_out_l;
  logic                 pending;
  logic [DATAWIDTH-1:0] acc      [NUM];
  logic [DATAWIDTH-1:0] lane_in  [NUM];
  logic [DATAWIDTH-1:0] lane_max [NUM];
  logic [DATAWIDTH-1:0] tree_max;
  logic [DATAWIDTH-1:0] max_q;

  assign start_acc  = (state == ST_IDLE) && bus.start;
  assign issue_last = (addr_q == limit_q);
  assign tag_out_v  = tag_v[RD_LAT-1];
  assign tag_out_l  = tag_l[RD_LAT-1];
  assign pending    = |tag_v;

  // State register.
  // NOTE: clocked state always uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state and control decode.
  // NOTE: every signal gets a default first, so no path leaves one unassigned (no latches).
  always_comb begin
    state_nx    = state;
    issue       = 1'b0;
    busy_c      = 1'b1;
    max_valid_c = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_c = 1'b0;
        if (bus.start) state_nx = ST_READ;
      end
      ST_READ: begin
        issue = 1'b1;
        if (issue_last) state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (!pending) state_nx = ST_REDUCE;
      end
      ST_REDUCE: state_nx = ST_DONE;
      ST_DONE: begin
        max_valid_c = 1'b1;
        state_nx    = ST_IDLE;
      end
      default: begin
        busy_c   = 1'b0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Latch the request and step the read address once per issued read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      limit_q      <= '0;
      last_valid_q <= '0;
      addr_q       <= '0;
    end else if (start_acc) begin
      limit_q      <= bus.addr_limit;
      last_valid_q <= bus.last_valid;
      addr_q       <= '0;
    end else if (issue && !issue_last) begin
      addr_q <= addr_q + 1'b1;
    end
  end

  // {valid, last} tags travel alongside each read for RD_LAT cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_v <= '0;
      tag_l <= '0;
    end else begin
      tag_v[0] <= issue;
      tag_l[0] <= issue && issue_last;
      for (int i = 1; i < RD_LAT; i++) begin
        tag_v[i] <= tag_v[i-1];
        tag_l[i] <= tag_l[i-1];
      end
    end
  end

  // Split the read word into lanes; lanes past last_valid on the final word become -inf.
  always_comb begin
    for (int i = 0; i < NUM; i++) begin
      lane_in[i] = bus.inp[DATAWIDTH*i +: DATAWIDTH];
      if (tag_out_l && (last_valid_q != '0) && (int'(last_valid_q) < NUM) &&
          (i >= int'(last_valid_q))) begin
        lane_in[i] = NEG_INF;
      end
    end
  end

  for (genvar i = 0; i < NUM; i++) begin : g_lane
    fp_max2 #(.DATAWIDTH(DATAWIDTH)) u_lane_max (
      .a (acc[i]),
      .b (lane_in[i]),
      .y (lane_max[i])
    );
  end

  // Per-lane running maximum, restarted at -inf by each accepted start.
  // NOTE: the accumulator array is only NUM words of flops and must hold -inf before
  // the first compare, so it is reset like any other register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM; i++) acc[i] <= NEG_INF;
    end else if (start_acc) begin
      for (int i = 0; i < NUM; i++) acc[i] <= NEG_INF;
    end else if (tag_out_v) begin
      for (int i = 0; i < NUM; i++) acc[i] <= lane_max[i];
    end
  end

  // Reduction tree over the lanes, padded with -inf; the lower lane sits on the 'a' side.
  for (genvar l = 0; l <= LOGN; l++) begin : g_lvl
    logic [DATAWIDTH-1:0] v [PADN >> l];
    if (l == 0) begin : g_leaf
      for (genvar i = 0; i < PADN; i++) begin : g_i
        if (i < NUM) begin : g_real
          assign v[i] = acc[i];
        end else begin : g_pad
          assign v[i] = NEG_INF;
        end
      end
    end else begin : g_node
      for (genvar i = 0; i < (PADN >> l); i++) begin : g_i
        fp_max2 #(.DATAWIDTH(DATAWIDTH)) u_node (
          .a (g_lvl[l-1].v[2*i]),
          .b (g_lvl[l-1].v[2*i+1]),
          .y (v[i])
        );
      end
    end
  end

  assign tree_max = g_lvl[LOGN].v[0];

`ifdef SOFTMAX_NAN_CHECK_EN
  logic any_nan;
  logic nan_sticky;
  logic nan_flag_q;

  // A NaN has an all-ones exponent and a non-zero mantissa; masked lanes are -inf, never NaN.
  always_comb begin
    any_nan = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      if ((&lane_in[i][DATAWIDTH-2:MANTWIDTH]) && (|lane_in[i][MANTWIDTH-1:0])) any_nan = 1'b1;
    end
  end

  // Result register; a NaN seen anywhere in the run forces the canonical qNaN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      max_q      <= '0;
      nan_sticky <= 1'b0;
      nan_flag_q <= 1'b0;
    end else begin
      if (start_acc) begin
        nan_sticky <= 1'b0;
        nan_flag_q <= 1'b0;
      end else if (tag_out_v && any_nan) begin
        nan_sticky <= 1'b1;
      end
      if (state == ST_REDUCE) begin
        max_q      <= nan_sticky ? QNAN : tree_max;
        nan_flag_q <= nan_sticky;
      end
    end
  end

  assign bus.nan_flag = nan_flag_q;
`else
  // Result register, loaded once from the reduction tree and held until the next result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  max_q <= '0;
    else if (state == ST_REDUCE) max_q <= tree_max;
  end
`endif

  assign bus.rd_en     = issue;
  assign bus.addr      = addr_q;
  assign bus.busy      = busy_c;
  assign bus.max_out   = max_q;
  assign bus.max_valid = max_valid_c;

endmodule

// File: tb/tb_softmax_max_reduce.sv
// Self-checking bench: two instances (4 lanes / latency 1 and 3 lanes / latency 3),
// each fed by a small latency-matched memory model; expected results come from an
// independent sign-magnitude reference and are queued at start, checked at max_valid.
module tb_softmax_max_reduce;

  localparam int NUM_A = 4;
  localparam int NUM_B = 3;
  localparam int RL_A  = 1;
  localparam int RL_B  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [15:0] val;
    bit          nan;
    int          cyc;
  } exp_t;

  exp_t sb_q [$];

  logic [15:0] mem_a [256][NUM_A];
  logic [15:0] mem_b [256][NUM_B];
  logic [7:0]  ra;
  logic [7:0]  rb [RL_B];

  softmax_max_reduce_if #(.DATAWIDTH(16), .NUM(NUM_A), .ADDRSIZE(8)) ifa ();
  softmax_max_reduce_if #(.DATAWIDTH(16), .NUM(NUM_B), .ADDRSIZE(8)) ifb ();

  softmax_max_reduce #(
    .DATAWIDTH(16), .EXPWIDTH(5), .MANTWIDTH(10), .NUM(NUM_A), .ADDRSIZE(8), .RD_LAT(RL_A)
  ) u_dut_a (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifa)
  );

  softmax_max_reduce #(
    .DATAWIDTH(16), .EXPWIDTH(5), .MANTWIDTH(10), .NUM(NUM_B), .ADDRSIZE(8), .RD_LAT(RL_B)
  ) u_dut_b (
    .clk   (clk),
    .reset (rst_n),
    .bus   (ifb)
  );

  // Memory models: address registered each edge, data appears RD_LAT cycles after issue.
  always @(posedge clk) begin
    ra    <= ifa.addr;
    rb[0] <= ifb.addr;
    rb[1] <= rb[0];
    rb[2] <= rb[1];
  end

  assign ifa.inp = {mem_a[ra][3], mem_a[ra][2], mem_a[ra][1], mem_a[ra][0]};
  assign ifb.inp = {mem_b[rb[2]][2], mem_b[rb[2]][1], mem_b[rb[2]][0]};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference ordering written directly on sign/magnitude; +0 and -0 are equal.
  function automatic bit fp_gt(input logic [15:0] a, input logic [15:0] b);
    if (a[14:0] == 15'h0 && b[14:0] == 15'h0) return 1'b0;
    if (a[15] != b[15]) return b[15];
    if (!a[15]) return a[14:0] > b[14:0];
    return a[14:0] < b[14:0];
  endfunction

  function automatic exp_t model(input bit sel, input int lim, input int lv);
    exp_t        e;
    logic [15:0] best [4];
    logic [15:0] x;
    int          num;
    bit          nan_seen;
    nan_seen = 1'b0;
    num = sel ? NUM_B : NUM_A;
    for (int l = 0; l < num; l++) begin
      best[l] = 16'hFC00;
      for (int w = 0; w <= lim; w++) begin
        if (!(w == lim && lv != 0 && lv < num && l >= lv)) begin
          x = sel ? mem_b[w][l] : mem_a[w][l];
          if (x[14:10] == 5'h1F && x[9:0] != 10'h0) nan_seen = 1'b1;
          if (fp_gt(x, best[l])) best[l] = x;
        end
      end
    end
    e.val = best[0];
    for (int l = 1; l < num; l++) begin
      if (fp_gt(best[l], e.val)) e.val = best[l];
    end
`ifdef SOFTMAX_NAN_CHECK_EN
    if (nan_seen) e.val = 16'h7E00;
`endif
    e.nan = nan_seen;
    e.cyc = lim + 1 + (sel ? RL_B : RL_A) + 3;
    return e;
  endfunction

  task automatic set_a(input int w, input logic [15:0] l0, l1, l2, l3);
    mem_a[w][0] = l0; mem_a[w][1] = l1; mem_a[w][2] = l2; mem_a[w][3] = l3;
  endtask

  task automatic set_b(input int w, input logic [15:0] l0, l1, l2);
    mem_b[w][0] = l0; mem_b[w][1] = l1; mem_b[w][2] = l2;
  endtask

  task automatic fill_random(input bit sel, input int lim);
    for (int w = 0; w <= lim; w++) begin
      for (int l = 0; l < (sel ? NUM_B : NUM_A); l++) begin
        if (sel) mem_b[w][l] = 16'($urandom_range(0, 16'hFFFF));
        else     mem_a[w][l] = 16'($urandom_range(0, 16'hFFFF));
      end
    end
  endtask

  task automatic sample(input bit sel, output logic rd, output logic [7:0] ad, output logic bz,
                        output logic mv, output logic [15:0] mo, output logic nf);
    rd = sel ? ifb.rd_en     : ifa.rd_en;
    ad = sel ? ifb.addr      : ifa.addr;
    bz = sel ? ifb.busy      : ifa.busy;
    mv = sel ? ifb.max_valid : ifa.max_valid;
    mo = sel ? ifb.max_out   : ifa.max_out;
`ifdef SOFTMAX_NAN_CHECK_EN
    nf = sel ? ifb.nan_flag  : ifa.nan_flag;
`else
    nf = 1'b0;
`endif
  endtask

  // One transaction: poke_cyc > 0 pulses start (or reset when poke_rst) in that cycle.
  task automatic run(input bit sel, input int lim, input int lv, input int poke_cyc,
                     input bit poke_rst);
    exp_t        e, got_e;
    int          rd_cnt, rd_first, extra;
    bit          addr_ok, busy_ok, done;
    logic        rd, bz, mv, nf;
    logic [7:0]  ad;
    logic [15:0] mo;
    rd_cnt = 0; rd_first = 0; extra = 0;
    addr_ok = 1'b1; busy_ok = 1'b1; done = 1'b0;
    e = model(sel, lim, lv);
    sb_q.push_back(e);
    @(negedge clk);
    if (sel) begin
      ifb.start = 1'b1; ifb.addr_limit = 8'(lim); ifb.last_valid = 2'(lv);
    end else begin
      ifa.start = 1'b1; ifa.addr_limit = 8'(lim); ifa.last_valid = 3'(lv);
    end
    @(posedge clk);
    #1;
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    for (int c = 1; c <= 400 && !done; c++) begin
      @(negedge clk);
      sample(sel, rd, ad, bz, mv, mo, nf);
      ifa.start = 1'b0;
      ifb.start = 1'b0;
      if (c == poke_cyc) begin
        if (poke_rst) begin
          rst_n = 1'b0;
          #1;
          sample(sel, rd, ad, bz, mv, mo, nf);
          check("rst_rd_en", 32'(rd), 0);
          check("rst_addr", 32'(ad), 0);
          check("rst_busy", 32'(bz), 0);
          check("rst_max_out", 32'(mo), 0);
          check("rst_max_valid", 32'(mv), 0);
          check("rst_nan_flag", 32'(nf), 0);
          sb_q.delete();
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end else if (sel) begin
          ifb.start = 1'b1;
        end else begin
          ifa.start = 1'b1;
        end
      end
      if (rd) begin
        rd_cnt++;
        if (rd_first == 0) rd_first = c;
        if (ad != 8'(c - 1)) addr_ok = 1'b0;
      end
      if (!bz) busy_ok = 1'b0;
`ifdef SOFTMAX_NAN_CHECK_EN
      if (c == 1) check("nan_clr_on_start", 32'(nf), 0);
`endif
      if (mv) begin
        done = 1'b1;
        if (sb_q.size() == 0) begin
          check("unexpected_max_valid", 1, 0);
        end else begin
          got_e = sb_q.pop_front();
          check("max_out", 32'(mo), 32'(got_e.val));
          check("max_valid_cycle", 32'(c), 32'(got_e.cyc));
`ifdef SOFTMAX_NAN_CHECK_EN
          check("nan_flag", 32'(nf), 32'(got_e.nan));
`endif
        end
      end
    end
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    if (!done) begin
      check("timeout_max_valid", 0, 1);
      sb_q.delete();
      return;
    end
    check("rd_en_count", 32'(rd_cnt), 32'(lim + 1));
    check("rd_en_first", 32'(rd_first), 1);
    check("addr_sequence", 32'(addr_ok), 1);
    check("busy_held", 32'(busy_ok), 1);
    @(negedge clk);
    sample(sel, rd, ad, bz, mv, mo, nf);
    check("max_valid_pulse", 32'(mv), 0);
    check("busy_clear", 32'(bz), 0);
    check("max_out_hold", 32'(mo), 32'(e.val));
    for (int k = 0; k < 4; k++) begin
      if (rd) extra++;
      @(negedge clk);
      sample(sel, rd, ad, bz, mv, mo, nf);
    end
    check("no_extra_reads", 32'(extra), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        rd, bz, mv, nf;
    logic [7:0]  ad;
    logic [15:0] mo;
    rst_n = 1'b0;
    ifa.start = 1'b0; ifa.addr_limit = '0; ifa.last_valid = '0;
    ifb.start = 1'b0; ifb.addr_limit = '0; ifb.last_valid = '0;
    for (int w = 0; w < 256; w++) begin
      set_a(w, 16'h0, 16'h0, 16'h0, 16'h0);
      set_b(w, 16'h0, 16'h0, 16'h0);
    end
    repeat (3) @(negedge clk);
    sample(1'b0, rd, ad, bz, mv, mo, nf);
    check("reset_rd_en", 32'(rd), 0);
    check("reset_addr", 32'(ad), 0);
    check("reset_busy", 32'(bz), 0);
    check("reset_max_out", 32'(mo), 0);
    check("reset_max_valid", 32'(mv), 0);
    check("reset_nan_flag", 32'(nf), 0);
    sample(1'b1, rd, ad, bz, mv, mo, nf);
    check("reset_b_busy", 32'(bz), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Identical words, max 16'h4210 in cycle 10.
    for (int w = 0; w <= 5; w++) set_a(w, 16'h3800, 16'h4040, 16'h4210, 16'h993E);
    run(1'b0, 5, 0, 0, 1'b0);

    // All-negative single word.
    set_a(0, 16'hBC00, 16'hC000, 16'h993E, 16'hC400);
    run(1'b0, 0, 0, 0, 1'b0);

    // Signed-zero ties across lanes and across time keep the first pattern.
    set_a(0, 16'h8000, 16'h0000, 16'hBC00, 16'hC000);
    run(1'b0, 0, 0, 0, 1'b0);
    set_a(0, 16'h0000, 16'h8000, 16'hBC00, 16'hC000);
    run(1'b0, 0, 0, 0, 1'b0);
    set_a(0, 16'h8000, 16'hC000, 16'hC000, 16'hC000);
    set_a(1, 16'h0000, 16'hC000, 16'hC000, 16'hC000);
    run(1'b0, 1, 0, 0, 1'b0);

    // Last-word masking.
    for (int w = 0; w <= 2; w++) set_a(w, 16'h3C00, 16'h4000, 16'h0000, 16'hC000);
    set_a(3, 16'h3800, 16'h3C00, 16'hBC00, 16'h7BFF);
    run(1'b0, 3, 2, 0, 1'b0);
    run(1'b0, 3, 0, 0, 1'b0);
    run(1'b0, 3, 4, 0, 1'b0);
    run(1'b0, 3, 3, 0, 1'b0);

    // Random words and masks.
    for (int t = 0; t < 4; t++) begin
      int lim;
      lim = $urandom_range(0, 9);
      fill_random(1'b0, lim);
      run(1'b0, lim, $urandom_range(0, 5), 0, 1'b0);
    end

    // 3 lanes, latency 3; start pulse while busy must be ignored.
    set_b(0, 16'hC000, 16'h3C00, 16'h0400);
    set_b(1, 16'h4400, 16'h4600, 16'hBC00);
    set_b(2, 16'h4500, 16'h4700, 16'h4200);
    run(1'b1, 2, 0, 3, 1'b0);
    run(1'b1, 2, 1, 0, 1'b0);
    for (int t = 0; t < 3; t++) begin
      int lim;
      lim = $urandom_range(0, 6);
      fill_random(1'b1, lim);
      run(1'b1, lim, $urandom_range(0, 3), 0, 1'b0);
    end

    // Reset in the middle of READ, then a clean run.
    for (int w = 0; w <= 5; w++) set_a(w, 16'h3800, 16'h4040, 16'h4210, 16'h993E);
    run(1'b0, 5, 0, 3, 1'b1);
    set_a(2, 16'h5000, 16'h0000, 16'h0000, 16'h0000);
    run(1'b0, 5, 0, 0, 1'b0);

`ifdef SOFTMAX_NAN_CHECK_EN
    set_a(3, 16'h3800, 16'h7C01, 16'h4210, 16'h993E);
    run(1'b0, 5, 0, 0, 1'b0);
    set_a(3, 16'h3800, 16'h4040, 16'h4210, 16'h993E);
    run(1'b0, 5, 0, 0, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/softmax_max_reduce.md
# softmax_max_reduce

Parametrised max-search stage of the softmax pipeline: streams a vector of `NUM`-lane floating-point words from the operand memory, addresses `0..addr_limit`, and reduces them to the single global maximum used by the subsequent subtract/exp stages. It generalises the fixed 4×FP16 max pass in three ways: configurable lane count and format, configurable memory read latency, and masking of a partially filled last word.

## Interface
- `DATAWIDTH`, 16: float width; must equal 1+`EXPWIDTH`+`MANTWIDTH`
- `EXPWIDTH`, 5: exponent bits
- `MANTWIDTH`, 10: mantissa bits
- `NUM`, 4: lanes per memory word, ≥1, any value
- `ADDRSIZE`, 8: memory address width
- `RD_LAT`, 1: memory read latency in cycles, ≥1
- `LW` (localparam), $clog2(NUM+1): width of `last_valid`

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock
- `reset` in 1: asynchronous, active-low (0 = in reset)
- `start` in 1: single-cycle request; sampled in IDLE only
- `addr_limit` in `ADDRSIZE`: last address, inclusive; sampled with `start`
- `last_valid` in `LW`: valid lanes in word `addr_limit` (lanes 0..n-1); 0 or ≥`NUM` means all; sampled with `start`
- `inp` in `DATAWIDTH*NUM`: read data, lane i at `[DATAWIDTH*(i+1)-1:DATAWIDTH*i]`
- `rd_en` out 1: read strobe
- `addr` out `ADDRSIZE`: read address
- `busy` out 1: high from the cycle after `start` until `max_valid`, inclusive
- `max_out` out `DATAWIDTH`: result; held until next `max_valid`
- `max_valid` out 1: one-cycle result pulse
- `nan_flag` out 1: only with `SOFTMAX_NAN_CHECK_EN`

## Operation
- FSM states: IDLE → READ → DRAIN → REDUCE → DONE → IDLE.
- IDLE: `start`=1 latches `addr_limit` and `last_valid`, clears all lane accumulators to -inf (sign=1, exp all ones, mant 0), and moves to READ.
- READ: `rd_en`=1 and `addr` = 0,1,…,`addr_limit`, one address per cycle. After the last issue the FSM moves to DRAIN.
- A `RD_LAT`-deep shift register carries {valid, last} tags alongside each read. When a tag emerges, `inp` is accumulated: acc[i] = max(acc[i], lane i).
- On the tagged-last word, lanes ≥ latched `last_valid` are replaced by -inf before comparison.
- DRAIN: waits until the last tag is consumed, then moves to REDUCE.
- REDUCE: one combinational tree over acc[0..NUM-1], padded with -inf to a power of 2; the result is registered into `max_out`.
- DONE: `max_valid`=1 for one cycle, then IDLE.
- Comparison uses an ordered key: if sign=1, key = ~x; else key = x with MSB set. The larger key wins.
- +0 and -0 compare equal. On a tie the lower lane/earlier value is kept; the stored bit pattern is unchanged.
- `start` outside IDLE is ignored. `addr_limit`=0 produces a single read.
- Reset asserted at any point: FSM → IDLE, in-flight tags discarded, all outputs → reset values.

## Timing
- Reset values: `rd_en`=0, `addr`=0, `busy`=0, `max_out`=0, `max_valid`=0, `nan_flag`=0.
- `start` sampled high at edge E0. `rd_en` is high for the N = `addr_limit`+1 cycles following E0, with address k in cycle k+1.
- Data for address k must be valid `RD_LAT` cycles after the cycle in which address k was issued.
- `max_valid` is asserted in cycle N+`RD_LAT`+3 after E0. Example: `addr_limit`=5, `RD_LAT`=1 → cycle 10.
- The earliest accepted next `start` is the cycle after `max_valid`.

## Configuration
- `SOFTMAX_NAN_CHECK_EN` defined:
  - A NaN (exp all ones, mant≠0) in any valid lane sets a sticky flag.
  - At DONE, `max_out` is forced to canonical qNaN (sign 0, exp all ones, mant MSB only; 16'h7E00 for FP16) and `nan_flag`=1 alongside `max_valid`.
  - Both are cleared on the next `start`.
- Undefined:
  - No `nan_flag` port.
  - NaNs are ordered by key like any other pattern (positive NaN > +inf).

## Structure
- `softmax_pkg` holds:
  - FSM state enum
  - `fp_neg_inf`/`fp_qnan` constant functions of `EXPWIDTH`/`MANTWIDTH`
  - `fp_key` ordering function
- Sub-module `fp_max2`: combinational two-input max, parametrised on `DATAWIDTH`. Used by both the lane accumulators and the reduction tree.

## Test plan
- FP16, `NUM`=4, `RD_LAT`=1, `addr_limit`=5, every word {16'h3800, 16'h4040, 16'h4210, 16'h993E} → `max_out`=16'h4210, `max_valid` in cycle 10, `rd_en` high exactly cycles 1–6.
- All-negative data {16'hBC00, 16'hC000, 16'h993E, 16'hC400}, `addr_limit`=0 → `max_out`=16'h993E; {16'h8000, 16'h0000} tie → first-seen pattern kept.
- `last_valid`=2 with 16'h7BFF in lane 3 of the last word only, other lanes ≤16'h4000 → `max_out`=16'h4000; same run with `last_valid`=0 → 16'h7BFF.
- `NUM`=3, `RD_LAT`=3, `addr_limit`=2 → correct max and `max_valid` in cycle 9; a `start` pulse while `busy` causes no extra reads.
- `reset`=0 for one cycle during READ → all outputs return to reset values immediately; a fresh `start` then completes normally.
- `SOFTMAX_NAN_CHECK_EN` defined, 16'h7C01 in word 3 → `max_out`=16'h7E00 and `nan_flag`=1 with `max_valid`; both cleared by the next `start`.
